apb2axi_fifo_ctl: RTL and testbench



---
 rtl/apb2axi_fifo_ctl_if.sv | 22 ++
 rtl/apb2axi_fifo_ctl.sv | 116 +++++++++++
 tb/tb_apb2axi_fifo_ctl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb2axi_fifo_ctl_if.sv
// apb2axi_fifo_ctl_if: push/pop valid-ready bundle for the APB-to-AXI buffer FIFO.
// The slave modport is the FIFO's view; the master modport is the producer/consumer side.
interface apb2axi_fifo_ctl_if #(
   parameter int ENTRY_WIDTH = 64
);
   logic                   push_vld;
   logic                   push_rdy;
   logic [ENTRY_WIDTH-1:0] push_data;
   logic                   pop_vld;
   logic                   pop_rdy;
   logic [ENTRY_WIDTH-1:0] pop_data;

   modport master (
      output push_vld, push_data, pop_rdy,
      input  push_rdy, pop_vld, pop_data
   );

   modport slave (
      input  push_vld, push_data, pop_rdy,
      output push_rdy, pop_vld, pop_data
   );
endinterface

// File: rtl/apb2axi_fifo_ctl.sv
// apb2axi_fifo_ctl: arbitrary-depth valid/ready FIFO with occupancy level,
// almost-full/almost-empty flags, synchronous flush and high-water-mark.
// The read port is first-word fall-through straight out of the register array.
// Optional zero-latency empty bypass is enabled with `define APB2AXI_FIFO_BYPASS_EN.
module apb2axi_fifo_ctl #(
   parameter int ENTRY_WIDTH = 64,
   parameter int FIFO_DEPTH  = 16,
   parameter int AF_THRESH   = FIFO_DEPTH - 2,
   parameter int AE_THRESH   = 1,
   localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    hwm_clr,
   apb2axi_fifo_ctl_if.slave       bus,
   output logic [CNT_W-1:0]        level,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [CNT_W-1:0]        hwm
);

   logic [ENTRY_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] hwm_q, hwm_d;

   logic empty;
   logic full;
   logic pushRdy;
   logic popVld;
   logic doPush;
   logic doPop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == CNT_W'(FIFO_DEPTH));
   assign pushRdy = !full && !flush;

`ifdef APB2AXI_FIFO_BYPASS_EN
   logic bypass;
   assign bypass       = empty && bus.push_vld && bus.pop_rdy && !flush;
   assign popVld       = (!empty && !flush) || bypass;
   assign bus.pop_data = bypass ? bus.push_data : mem[rdPtr_q];
   assign doPush       = bus.push_vld && pushRdy && !bypass;
`else
   assign popVld       = !empty && !flush;
   assign bus.pop_data = mem[rdPtr_q];
   assign doPush       = bus.push_vld && pushRdy;
`endif

   assign doPop        = popVld && bus.pop_rdy && !empty;
   assign bus.push_rdy = pushRdy;
   assign bus.pop_vld  = popVld;

   assign level        = level_q;
   assign hwm          = hwm_q;
   assign almost_full  = (level_q >= CNT_W'(AF_THRESH));
   assign almost_empty = (level_q <= CNT_W'(AE_THRESH));

   // Next-state for pointers, level and high-water-mark; flush overrides everything.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      hwm_d   = hwm_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         level_d = '0;
         hwm_d   = '0;
      end else begin
         if (doPush) begin
            wrPtr_d = (wrPtr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
         end
         if (doPop) begin
            rdPtr_d = (rdPtr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
         end
         if (doPush && !doPop) begin
            level_d = level_q + CNT_W'(1);
         end else if (doPop && !doPush) begin
            level_d = level_q - CNT_W'(1);
         end
         if (hwm_clr) begin
            hwm_d = level_d;
         end else if (level_d > hwm_q) begin
            hwm_d = level_d;
         end
      end
   end

   // Control state registers, cleared asynchronously so reset takes effect mid-transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
         hwm_q   <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
         hwm_q   <= hwm_d;
      end
   end

   // Storage array is deliberately left unreset; only accepted pushes write it.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr_q] <= bus.push_data;
      end
   end

endmodule

// File: tb/tb_apb2axi_fifo_ctl.sv
// tb_apb2axi_fifo_ctl: directed test of apb2axi_fifo_ctl at depth 5 (AF=3, AE=1).
// Honors `define APB2AXI_FIFO_BYPASS_EN for the empty-bypass step.
module tb_apb2axi_fifo_ctl;

   localparam int EW    = 8;
   localparam int DEPTH = 5;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          reset;
   logic          flush;
   logic          hwm_clr;
   logic [CW-1:0] level;
   logic          almost_full;
   logic          almost_empty;
   logic [CW-1:0] hwm;

   int vectors;
   int miscompares;

   apb2axi_fifo_ctl_if #(.ENTRY_WIDTH(EW)) bus ();

   apb2axi_fifo_ctl #(
      .ENTRY_WIDTH (EW),
      .FIFO_DEPTH  (DEPTH),
      .AF_THRESH   (3),
      .AE_THRESH   (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .hwm_clr      (hwm_clr),
      .bus          (bus.slave),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .hwm          (hwm)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive all inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic pv, input logic [EW-1:0] pd, input logic pr,
                                input logic fl, input logic hc);
      bus.push_vld  = pv;
      bus.push_data = pd;
      bus.pop_rdy   = pr;
      flush         = fl;
      hwm_clr       = hc;
      #1;
   endtask

   // Advance one clock and sample just after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset state");
      checkOutput("rst_push_rdy", 32'(bus.push_rdy), 32'd1);
      checkOutput("rst_pop_vld", 32'(bus.pop_vld), 32'd0);
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_af", 32'(almost_full), 32'd0);
      checkOutput("rst_ae", 32'(almost_empty), 32'd1);
      checkOutput("rst_hwm", 32'(hwm), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cycle();

      $display("[TB] fill to full, stall, full push+pop, drain");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
         checkOutput("fill_push_rdy", 32'(bus.push_rdy), 32'd1);
         cycle();
      end
      checkOutput("full_level", 32'(level), 32'd5);
      checkOutput("full_push_rdy", 32'(bus.push_rdy), 32'd0);
      checkOutput("full_af", 32'(almost_full), 32'd1);
      checkOutput("full_hwm", 32'(hwm), 32'd5);
      checkOutput("full_head", 32'(bus.pop_data), 32'hA0);
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      cycle();
      checkOutput("stall_level", 32'(level), 32'd5);
      applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      checkOutput("fullpp_push_rdy", 32'(bus.push_rdy), 32'd0);
      checkOutput("fullpp_pop_vld", 32'(bus.pop_vld), 32'd1);
      cycle();
      checkOutput("fullpp_level", 32'(level), 32'd4);
      checkOutput("fullpp_head", 32'(bus.pop_data), 32'hA1);
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      checkOutput("refill_push_rdy", 32'(bus.push_rdy), 32'd1);
      cycle();
      checkOutput("refill_level", 32'(level), 32'd5);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         checkOutput("drain_pop_vld", 32'(bus.pop_vld), 32'd1);
         checkOutput("drain_data", 32'(bus.pop_data), 32'(8'hA1 + i));
         cycle();
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("empty_pop_vld", 32'(bus.pop_vld), 32'd0);
      checkOutput("empty_level", 32'(level), 32'd0);
      checkOutput("empty_ae", 32'(almost_empty), 32'd1);

      $display("[TB] streaming across pointer wrap");
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
         cycle();
      end
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 8'(8'hB2 + i), 1'b1, 1'b0, 1'b0);
         checkOutput("wrap_data", 32'(bus.pop_data), 32'(8'hB0 + i));
         cycle();
         checkOutput("wrap_level", 32'(level), 32'd2);
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         checkOutput("wrap_tail", 32'(bus.pop_data), 32'(8'hBC + i));
         cycle();
      end
      checkOutput("wrap_end_level", 32'(level), 32'd0);
      checkOutput("wrap_hwm", 32'(hwm), 32'd5);

      $display("[TB] flush with concurrent push");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
         cycle();
      end
      checkOutput("preflush_level", 32'(level), 32'd3);
      applyStimulus(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_push_rdy", 32'(bus.push_rdy), 32'd0);
      checkOutput("flush_pop_vld", 32'(bus.pop_vld), 32'd0);
      cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("postflush_level", 32'(level), 32'd0);
      checkOutput("postflush_hwm", 32'(hwm), 32'd0);
      checkOutput("postflush_pop_vld", 32'(bus.pop_vld), 32'd0);
      checkOutput("postflush_ae", 32'(almost_empty), 32'd1);
      applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
      cycle();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("postflush_data", 32'(bus.pop_data), 32'hD0);
      checkOutput("postflush_hwm1", 32'(hwm), 32'd1);
      cycle();
      checkOutput("postflush_drained", 32'(level), 32'd0);

      $display("[TB] high-water-mark and threshold edges");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0);
         cycle();
         if (i == 1) begin
            checkOutput("lvl2_ae", 32'(almost_empty), 32'd0);
            checkOutput("lvl2_af", 32'(almost_full), 32'd0);
         end
         if (i == 2) begin
            checkOutput("lvl3_af", 32'(almost_full), 32'd1);
         end
      end
      checkOutput("hwm_fill", 32'(hwm), 32'd4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         checkOutput("hwm_drain_data", 32'(bus.pop_data), 32'(8'hE0 + i));
         cycle();
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("hwm_after_drain", 32'(hwm), 32'd4);
      checkOutput("lvl1_ae", 32'(almost_empty), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      cycle();
      checkOutput("hwm_cleared", 32'(hwm), 32'd1);
      applyStimulus(1'b1, 8'hE4, 1'b0, 1'b0, 1'b0);
      cycle();
      checkOutput("hwm_regrow", 32'(hwm), 32'd2);
      checkOutput("hwm_head", 32'(bus.pop_data), 32'hE3);

      $display("[TB] asynchronous reset mid-burst");
      applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
      cycle();
      checkOutput("prereset_level", 32'(level), 32'd3);
      applyStimulus(1'b1, 8'hF1, 1'b1, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_push_rdy", 32'(bus.push_rdy), 32'd1);
      checkOutput("async_pop_vld", 32'(bus.pop_vld), 32'd0);
      checkOutput("async_level", 32'(level), 32'd0);
      checkOutput("async_hwm", 32'(hwm), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      cycle();
      checkOutput("postreset_level", 32'(level), 32'd0);

      $display("[TB] push into empty FIFO with consumer ready");
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      checkOutput("byp_push_rdy", 32'(bus.push_rdy), 32'd1);
`ifdef APB2AXI_FIFO_BYPASS_EN
      checkOutput("byp_pop_vld", 32'(bus.pop_vld), 32'd1);
      checkOutput("byp_pop_data", 32'(bus.pop_data), 32'h55);
      cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("byp_level", 32'(level), 32'd0);
      checkOutput("byp_hwm", 32'(hwm), 32'd0);
      checkOutput("byp_after_vld", 32'(bus.pop_vld), 32'd0);
`else
      checkOutput("nobyp_pop_vld", 32'(bus.pop_vld), 32'd0);
      cycle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("nobyp_level", 32'(level), 32'd1);
      checkOutput("nobyp_pop_vld1", 32'(bus.pop_vld), 32'd1);
      checkOutput("nobyp_pop_data", 32'(bus.pop_data), 32'h55);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
